layer_sequencer: RTL and testbench

// - Sequences one fully-connected layer through a single shared neuron MAC (Q1.15, ReLU/saturating).
// - Per neuron n: streams NUM_INPUTS activations, weights and bias from 1-cycle-latency sync RAMs into the MAC.
// - Collects the MAC result and writes it to the layer result buffer at address n.
// - Sits between the layer memories and the MAC; the top-level network FSM controls it via start/done.

---
 rtl/net_pkg.sv | 19 +
 rtl/layer_sequencer_if.sv | 38 +++
 rtl/layer_addr_gen.sv | 48 ++++
 rtl/layer_sequencer.sv | 108 ++++++++++
 tb/tb_layer_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/net_pkg.sv
// Shared network package: Q1.15 width, sequencer state encoding, layer sizes
// used by the network-level FSM, and an address-width helper.
package net_pkg;

  localparam int DATA_W     = 16;   // Q1.15
  localparam int L1_INPUTS  = 784;
  localparam int L1_NEURONS = 10;
  localparam int L1_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, DRAIN, WRITE, DONE
  } seq_state_t;

  // Address width that stays >= 1 bit for single-entry memories.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control, memory-address, MAC and result-buffer signals of one layer
// sequencer. master = sequencer side, slave = network FSM / memories / MAC.
interface layer_sequencer_if import net_pkg::*; #(
  parameter int NUM_INPUTS  = L1_INPUTS,
  parameter int NUM_NEURONS = L1_NEURONS
);
  localparam int AW = addr_w(NUM_INPUTS);
  localparam int WW = addr_w(NUM_INPUTS * NUM_NEURONS);
  localparam int BW = addr_w(NUM_NEURONS);

  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic [AW-1:0]     act_addr;
  logic [WW-1:0]     w_addr;
  logic [BW-1:0]     b_addr;
  logic              mac_rst;
  logic              mac_valid;
  logic [DATA_W-1:0] mac_out;
  logic              mac_out_valid;
  logic              res_we;
  logic [BW-1:0]     res_addr;
  logic [DATA_W-1:0] res_wdata;

  modport master (
    input  start, mac_out, mac_out_valid,
    output busy, done, err, act_addr, w_addr, b_addr,
           mac_rst, mac_valid, res_we, res_addr, res_wdata
  );

  modport slave (
    output start, mac_out, mac_out_valid,
    input  busy, done, err, act_addr, w_addr, b_addr,
           mac_rst, mac_valid, res_we, res_addr, res_wdata
  );

endinterface

// File: rtl/layer_addr_gen.sv
// Input/neuron counters for the layer sequencer. The weight address is a
// running base (n*NUM_INPUTS, advanced by addition per neuron) plus i, so no
// multiplier is needed.
module layer_addr_gen import net_pkg::*; #(
  parameter int NUM_INPUTS  = L1_INPUTS,
  parameter int NUM_NEURONS = L1_NEURONS,
  localparam int AW = addr_w(NUM_INPUTS),
  localparam int WW = addr_w(NUM_INPUTS * NUM_NEURONS),
  localparam int BW = addr_w(NUM_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,     // layer accepted: restart at neuron 0, input 0
  input  logic          step,    // one input issued this cycle
  input  logic          nxt_n,   // advance to next neuron
  output logic [AW-1:0] act_addr,
  output logic [WW-1:0] w_addr,
  output logic [BW-1:0] b_addr,
  output logic          last_i,
  output logic          last_n
);

  logic [AW-1:0] i;
  logic [BW-1:0] n;
  logic [WW-1:0] base;

  // Counters: i wraps to 0 after the last input so each neuron starts clean.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      i    <= '0;
      n    <= '0;
      base <= '0;
    end else begin
      if (step) i <= last_i ? '0 : i + AW'(1);
      if (nxt_n) begin
        n    <= n + BW'(1);
        base <= base + WW'(NUM_INPUTS);
      end
    end
  end

  assign last_i   = (i == AW'(NUM_INPUTS - 1));
  assign last_n   = (n == BW'(NUM_NEURONS - 1));
  assign act_addr = i;
  assign b_addr   = n;
  assign w_addr   = base + WW'(i);

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer through a shared MAC: per neuron it
// streams activations/weights (bias held on b_addr), waits for the MAC
// result with a timeout, and writes it to the result buffer at address n.
module layer_sequencer import net_pkg::*; #(
  parameter int NUM_INPUTS  = L1_INPUTS,
  parameter int NUM_NEURONS = L1_NEURONS,
  parameter int TIMEOUT     = L1_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  layer_sequencer_if.master  bus
);

  localparam int TW = addr_w(TIMEOUT);

  seq_state_t        state;
  logic              issue_q;
  logic [TW-1:0]     tmo;
  logic              busy_r, done_r, err_r, res_we_r;
  logic [DATA_W-1:0] res_wdata_r;
  logic              last_i, last_n;
  logic [addr_w(NUM_NEURONS)-1:0] n;

  layer_addr_gen #(
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_NEURONS (NUM_NEURONS)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE && bus.start),
    .step     (state == STREAM),
    .nxt_n    (state == WRITE && !last_n),
    .act_addr (bus.act_addr),
    .w_addr   (bus.w_addr),
    .b_addr   (n),
    .last_i   (last_i),
    .last_n   (last_n)
  );

  // Layer FSM with registered status/write strobes; issue_q aligns mac_valid
  // with the 1-cycle RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_q     <= 1'b0;
      tmo         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      res_we_r    <= 1'b0;
      res_wdata_r <= '0;
    end else begin
      issue_q  <= (state == STREAM);
      done_r   <= 1'b0;
      res_we_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state  <= CLEAR;
          busy_r <= 1'b1;
          err_r  <= 1'b0;
        end
        CLEAR: state <= STREAM;
        STREAM: if (last_i) begin
          state <= DRAIN;
          tmo   <= '0;
        end
        DRAIN: begin
          if (bus.mac_out_valid) begin
            res_wdata_r <= bus.mac_out;
            res_we_r    <= 1'b1;
            state       <= WRITE;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        WRITE: begin
          if (last_n) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            state <= STREAM;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The MAC is held clear whenever this block is in reset or in CLEAR.
  assign bus.mac_rst   = ~rst_n | (state == CLEAR);
  assign bus.mac_valid = issue_q;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.b_addr    = n;
  assign bus.res_addr  = n;
  assign bus.res_we    = res_we_r;
  assign bus.res_wdata = res_wdata_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: 1-cycle sync RAM models, a behavioural Q1.15
// neuron (ReLU + saturate, self-clearing after each result) and a
// reference computed directly from the memory arrays.
module tb_layer_sequencer;
  import net_pkg::*;

  localparam int NI  = 4;
  localparam int NN  = 3;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_sequencer_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) bus ();

  layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memories
  logic [15:0] act_mem [NI];
  logic [15:0] w_mem   [NI*NN];
  logic [15:0] b_mem   [NN];
  logic [15:0] res_mem [NN];
  logic [15:0] act_q, w_q, b_q;
  logic        res_fill = 1'b0;

  always @(posedge clk) begin
    act_q <= act_mem[bus.act_addr];
    w_q   <= w_mem[bus.w_addr];
    b_q   <= b_mem[bus.b_addr];
    if (res_fill) begin
      for (int k = 0; k < NN; k++) res_mem[k] <= 16'hDEAD;
    end else if (bus.res_we) begin
      res_mem[bus.res_addr] <= bus.res_wdata;
    end
  end

  // Neuron arithmetic
  function automatic longint prod(input logic [15:0] a, input logic [15:0] b);
    return (longint'($signed(a)) * longint'($signed(b))) >>> 15;
  endfunction

  function automatic logic [15:0] sat_relu(input longint v);
    logic [63:0] t;
    if (v < 0) return 16'h0000;
    if (v > 32767) return 16'h7FFF;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [15:0] ref_res(input int n);
    longint s;
    s = longint'($signed(b_mem[n]));
    for (int i = 0; i < NI; i++) s += prod(act_mem[i], w_mem[n*NI + i]);
    return sat_relu(s);
  endfunction

  // Neuron model: accumulates NI valid inputs, then emits one result.
  longint      acc = 0;
  int          mcnt = 0;
  logic [15:0] mo = '0;
  logic        mo_v = 1'b0;
  logic        kill = 1'b0;

  always @(posedge clk) begin
    mo_v <= 1'b0;
    if (bus.mac_rst) begin
      acc  <= 0;
      mcnt <= 0;
    end else if (bus.mac_valid) begin
      if (mcnt == NI - 1) begin
        mo   <= sat_relu(acc + prod(act_q, w_q) + longint'($signed(b_q)));
        mo_v <= 1'b1;
        acc  <= 0;
        mcnt <= 0;
      end else begin
        acc  <= acc + prod(act_q, w_q);
        mcnt <= mcnt + 1;
      end
    end
  end

  assign bus.mac_out       = mo;
  assign bus.mac_out_valid = mo_v & ~kill;

  // Monitor: weight address behind each mac_valid, mac_valid count and
  // bias/result addresses per write, done pulses.
  logic        mon_clr = 1'b0;
  logic [3:0]  prev_w = '0;
  int          nv = 0;
  int          ndone = 0;
  int          wlog[$];
  int          vlog[$];
  int          blog[$];
  int          ralog[$];

  always @(negedge clk) begin
    prev_w <= bus.w_addr;
    if (mon_clr) begin
      nv    <= 0;
      ndone <= 0;
      wlog.delete(); vlog.delete(); blog.delete(); ralog.delete();
    end else begin
      if (bus.mac_valid) wlog.push_back(int'(prev_w));
      nv <= bus.res_we ? 0 : nv + (bus.mac_valid ? 1 : 0);
      if (bus.res_we) begin
        vlog.push_back(nv);
        blog.push_back(int'(bus.b_addr));
        ralog.push_back(int'(bus.res_addr));
      end
      ndone <= ndone + (bus.done ? 1 : 0);
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1; res_fill = 1'b1;
    @(negedge clk); @(negedge clk);
    mon_clr = 1'b0; res_fill = 1'b0;
  endtask

  // Start a layer (cycle 0 = start high) and return the cycle done appears.
  // With poke set, start is also raised mid-layer and during DONE.
  task automatic run_layer(input bit poke, output int cyc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    chk("clear_mac_rst", bus.mac_rst, 1);
    chk("clear_busy", bus.busy, 1);
    chk("err_cleared", bus.err, 0);
    while (!bus.done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.start = poke && (cyc == 5);
    end
    chk("done_seen", (cyc < 400), 1);
    bus.start = poke;
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    @(negedge clk);
    chk("still_idle", bus.busy, 0);
  endtask

  task automatic layer_check(input string tag, input bit poke);
    int cyc;
    clear_mon();
    run_layer(poke, cyc);
    chk({tag, "_done_cycle"}, cyc, 2 + NN*(NI+3));
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_ndone"}, ndone, 1);
    for (int n = 0; n < NN; n++)
      chk($sformatf("%s_res%0d", tag, n), res_mem[n], ref_res(n));
    chk({tag, "_nwrites"}, vlog.size(), NN);
    for (int k = 0; k < vlog.size(); k++) begin
      chk($sformatf("%s_nvalid%0d", tag, k), vlog[k], NI);
      chk($sformatf("%s_baddr%0d", tag, k), blog[k], k);
      chk($sformatf("%s_raddr%0d", tag, k), ralog[k], k);
    end
    chk({tag, "_nw"}, wlog.size(), NI*NN);
    for (int k = 0; k < wlog.size(); k++)
      chk($sformatf("%s_waddr%0d", tag, k), wlog[k], k);
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < NI; i++) act_mem[i] = a;
    for (int i = 0; i < NI*NN; i++) w_mem[i] = w;
    for (int i = 0; i < NN; i++) b_mem[i] = b;
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    fill(16'h0, 16'h0, 16'h0);
    for (int k = 0; k < NN; k++) res_mem[k] = 16'h0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mac_valid", bus.mac_valid, 0);
    chk("rst_res_we", bus.res_we, 0);
    chk("rst_mac_rst", bus.mac_rst, 1);
    chk("rst_act_addr", bus.act_addr, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    chk("rst_res_wdata", bus.res_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_mac_rst", bus.mac_rst, 0);

    // Nominal: 0.5*0.5 per term; four terms reach +1.0 and saturate.
    fill(16'h4000, 16'h4000, 16'h0000);
    layer_check("nom", 1'b0);

    // ReLU clamp on neuron 1 (weights -1.0), saturation on neuron 2.
    fill(16'h7FFF, 16'h1000, 16'h0000);
    for (int i = 0; i < NI; i++) begin
      w_mem[NI + i]   = 16'h8000;
      w_mem[2*NI + i] = 16'h7FFF;
    end
    b_mem[2] = 16'h7FFF;
    layer_check("relu", 1'b0);
    chk("relu_n1_zero", res_mem[1], 16'h0000);
    chk("sat_n2_max", res_mem[2], 16'h7FFF);

    // Randomized layers; the last one also pokes start while busy/in DONE.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) act_mem[i] = 16'($urandom);
      for (int i = 0; i < NI*NN; i++) w_mem[i] = 16'($urandom);
      for (int i = 0; i < NN; i++) b_mem[i] = 16'($urandom_range(0, 16'h3FFF));
      layer_check($sformatf("rnd%0d", r), (r == 3));
    end

    // Timeout: suppress the MAC's out_valid.
    fill(16'h2000, 16'h2000, 16'h0100);
    clear_mon();
    kill = 1'b1;
    run_layer(1'b0, cyc);
    kill = 1'b0;
    chk("tmo_done_cycle", cyc, 2 + NI + TMO);
    chk("tmo_err", bus.err, 1);
    chk("tmo_no_write", vlog.size(), 0);
    chk("tmo_ndone", ndone, 1);
    chk("tmo_res0_untouched", res_mem[0], 16'hDEAD);
    layer_check("after_tmo", 1'b0);

    // Reset during neuron 1 STREAM (cycles 9..12), then a clean restart.
    clear_mon();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);          // now in cycle 10
    chk("mid_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_busy", bus.busy, 0);
    chk("mid_mac_rst", bus.mac_rst, 1);
    chk("mid_done", bus.done, 0);
    chk("mid_mac_valid", bus.mac_valid, 0);
    chk("mid_res0_kept", res_mem[0], ref_res(0));
    chk("mid_res1_unwritten", res_mem[1], 16'hDEAD);
    rst_n = 1'b1;
    @(negedge clk);
    layer_check("restart", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

endmodule
